// File: rtl/ioctl_word_loader.sv
// Packs ioctl byte writes into DATA_W-wide words with byte enables, buffers them
// in a show-ahead FIFO and delivers them over a req/ack memory write port.
module ioctl_word_loader #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned BASE_ADDR     = 0,
  parameter logic [7:0]  INDEX_VAL     = 8'h00,
  parameter logic [7:0]  INDEX_MASK    = 8'hFF,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic                clk_48,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [7:0]          ioctl_index,
  output logic                ioctl_wait,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int NB  = DATA_W / 8;
  localparam int LB  = $clog2(NB);
  localparam int LBW = (LB > 0) ? LB : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  logic              accept_s;
  logic              fall_s;
  logic              full_be_s;
  logic              mismatch_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              push_ok_s;
  logic [LBW-1:0]    lane_s;
  logic [LBW-1:0]    pos_s;
  logic [ADDR_W-1:0] w_s;
  logic [NB-1:0]     byte_be_s;
  logic [DATA_W-1:0] byte_data_s;
  logic [DATA_W-1:0] byte_mask_s;

  logic              dl_q;
  logic              flush_q;
  logic              asm_valid_q, asm_valid_d;
  logic [ADDR_W-1:0] asm_addr_q, asm_addr_d;
  logic [DATA_W-1:0] asm_data_q, asm_data_d;
  logic [NB-1:0]     asm_be_q, asm_be_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wait_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [NB-1:0]     fifo_be_q   [FIFO_DEPTH];

  // Byte decode: target word address, lane and its position in the word.
  assign accept_s    = ioctl_download && ioctl_wr && ((ioctl_index & INDEX_MASK) == INDEX_VAL);
  assign fall_s      = dl_q && !ioctl_download;
  assign w_s         = ADDR_W'(ioctl_addr >> LB) + ADDR_W'(BASE_ADDR);
  assign lane_s      = (LB > 0) ? ioctl_addr[LBW-1:0] : '0;
  assign pos_s       = LITTLE_ENDIAN ? lane_s : (LBW'(NB - 1) - lane_s);
  assign byte_be_s   = NB'(1'b1) << pos_s;
  assign byte_data_s = DATA_W'(ioctl_dout) << {pos_s, 3'b000};
  assign byte_mask_s = DATA_W'(8'hFF) << {pos_s, 3'b000};

  assign full_be_s   = asm_valid_q && (asm_be_q == '1);
  assign mismatch_s  = accept_s && asm_valid_q && (asm_addr_q != w_s);
  assign push_s      = asm_valid_q && (full_be_s || flush_q || mismatch_s);

  assign pop_s       = (count_q != '0) && mem_ack;
  assign fifo_full_s = (count_q == CW'(FIFO_DEPTH));
  assign push_ok_s   = push_s && (!fifo_full_s || pop_s);

  // Assembler next state: push-and-reload, merge, or fresh load.
  always_comb begin
    asm_valid_d = asm_valid_q;
    asm_addr_d  = asm_addr_q;
    asm_data_d  = asm_data_q;
    asm_be_d    = asm_be_q;
    if (push_s) begin
      if (accept_s) begin
        asm_valid_d = 1'b1;
        asm_addr_d  = w_s;
        asm_data_d  = byte_data_s;
        asm_be_d    = byte_be_s;
      end else begin
        asm_valid_d = 1'b0;
        asm_addr_d  = '0;
        asm_data_d  = '0;
        asm_be_d    = '0;
      end
    end else if (accept_s) begin
      if (asm_valid_q) begin
        asm_data_d = (asm_data_q & ~byte_mask_s) | byte_data_s;
        asm_be_d   = asm_be_q | byte_be_s;
      end else begin
        asm_valid_d = 1'b1;
        asm_addr_d  = w_s;
        asm_data_d  = byte_data_s;
        asm_be_d    = byte_be_s;
      end
    end else begin
      asm_valid_d = asm_valid_q;
    end
  end

  // FIFO pointers, occupancy, overflow and window status.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push_ok_s);
    rd_ptr_d   = rd_ptr_q + PW'(pop_s);
    count_d    = count_q + CW'(push_ok_s) - CW'(pop_s);
    overflow_d = overflow_q | (push_s & ~push_ok_s);
    // Completion looks at next-state so done lands the cycle after the last transfer.
    done_d     = busy_q && !ioctl_download && !asm_valid_d && (count_d == '0);
    if (accept_s) begin
      busy_d = 1'b1;
    end else if (done_d) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      dl_q        <= 1'b0;
      flush_q     <= 1'b0;
      asm_valid_q <= 1'b0;
      asm_addr_q  <= '0;
      asm_data_q  <= '0;
      asm_be_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      dl_q        <= ioctl_download;
      flush_q     <= fall_s;
      asm_valid_q <= asm_valid_d;
      asm_addr_q  <= asm_addr_d;
      asm_data_q  <= asm_data_d;
      asm_be_q    <= asm_be_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= (count_q >= CW'(FIFO_DEPTH - 2));
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Word storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk_48) begin
    if (push_ok_s) begin
      fifo_addr_q[wr_ptr_q] <= asm_addr_q;
      fifo_data_q[wr_ptr_q] <= asm_data_q;
      fifo_be_q[wr_ptr_q]   <= asm_be_q;
    end else begin
      fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
    end
  end

  assign mem_req    = (count_q != '0);
  assign mem_addr   = mem_req ? fifo_addr_q[rd_ptr_q] : '0;
  assign mem_data   = mem_req ? fifo_data_q[rd_ptr_q] : '0;
  assign mem_be     = mem_req ? fifo_be_q[rd_ptr_q]   : '0;
  assign ioctl_wait = wait_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Scoreboard bench for ioctl_word_loader: stimulus pushes expected writes,
// negedge monitors pop and compare whenever a memory transfer occurs.
module tb_ioctl_word_loader;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        mem_ack;
  logic        ioctl_wait, mem_req, busy, done, overflow;
  logic [15:0] mem_addr, mem_data;
  logic [1:0]  mem_be;

  logic        en_b;
  logic        dl_b;
  logic        b_wait, b_req, b_busy, b_done, b_ovf;
  logic [15:0] b_addr, b_data;
  logic [1:0]  b_be;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  done_cnt = 0;
  bit  busy_seen = 1'b0;

  always #5 clk_48 = ~clk_48;
  assign dl_b = ioctl_download & en_b;

  ioctl_word_loader #(.DATA_W(16), .ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR('h100),
                      .INDEX_VAL(8'h00), .INDEX_MASK(8'hFF), .LITTLE_ENDIAN(1'b1)) dut (
    .clk_48(clk_48), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_be(mem_be), .busy(busy), .done(done), .overflow(overflow));

  ioctl_word_loader #(.DATA_W(16), .ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR('h100),
                      .INDEX_VAL(8'h00), .INDEX_MASK(8'hFF), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk_48(clk_48), .reset(reset), .ioctl_download(dl_b), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(b_wait), .mem_req(b_req), .mem_ack(1'b1), .mem_addr(b_addr),
    .mem_data(b_data), .mem_be(b_be), .busy(b_busy), .done(b_done), .overflow(b_ovf));

  function automatic logic [15:0] be_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_48);
      #1;
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honour);
    int guard = 0;
    @(posedge clk_48);
    #1;
    while (honour && ioctl_wait && guard < 300) begin
      @(posedge clk_48);
      #1;
      guard++;
    end
    if (guard >= 300) begin
      n_total++;
      $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, expected 0", ioctl_wait, guard);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_48);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic finish_window(input int exp_done);
    int guard = 0;
    ioctl_download = 1'b0;
    while (done_cnt < exp_done && guard < 100) begin
      cyc(1);
      guard++;
    end
    cyc(5);
    check("done_count", done_cnt, exp_done);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_data", mem_data, 16'h0000);
    check("rst_be", mem_be, 2'b00);
  endtask

  task automatic push_a(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    qb.push_back(e);
  endtask

  // Monitor for the little-endian instance plus done/busy bookkeeping.
  always @(negedge clk_48) begin
    wr_t e;
    if (!reset && mem_req && mem_ack) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %h data %h be %b, expected no write", mem_addr, mem_data, mem_be);
      end else begin
        e = qa.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_be", mem_be, e.be);
        check("wr_data", mem_data & be_mask(e.be), e.data & be_mask(e.be));
      end
    end
    if (!reset && done) done_cnt++;
    if (!reset && busy) busy_seen = 1'b1;
  end

  // Monitor for the big-endian instance, active only while it is enabled.
  always @(negedge clk_48) begin
    wr_t e;
    if (!reset && b_req) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write_be: got addr %h data %h be %b, expected no write", b_addr, b_data, b_be);
      end else begin
        e = qb.pop_front();
        check("be_wr_addr", b_addr, e.addr);
        check("be_wr_be", b_be, e.be);
        check("be_wr_data", b_data & be_mask(e.be), e.data & be_mask(e.be));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = 25'd0;
    ioctl_dout = 8'h00; ioctl_index = 8'h00; mem_ack = 1'b1; en_b = 1'b0;
    cyc(3);
    check_reset_outputs();
    reset = 1'b0;
    cyc(2);

    // Two full words, ack held high.
    ioctl_download = 1'b1;
    push_a(16'h0100, 16'h2211, 2'b11);
    push_a(16'h0101, 16'h4433, 2'b11);
    send_byte(25'd0, 8'h11, 1'b0);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b0);
    finish_window(1);

    // Partial final word flushed by the end of download, with cycle timing.
    ioctl_download = 1'b1;
    push_a(16'h0100, 16'h2211, 2'b11);
    push_a(16'h0101, 16'h0033, 2'b01);
    send_byte(25'd0, 8'h11, 1'b0);
    check("busy_rise", busy, 1'b1);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    ioctl_download = 1'b0;
    cyc(1);
    check("flush_req_early", mem_req, 1'b0);
    cyc(1);
    check("flush_req", mem_req, 1'b1);
    cyc(1);
    check("flush_done", done, 1'b1);
    check("flush_busy", busy, 1'b0);
    finish_window(2);

    // Address jump pushes a partial word; both byte orders.
    en_b = 1'b1;
    ioctl_download = 1'b1;
    push_a(16'h0100, 16'h00AA, 2'b01);
    push_a(16'h0103, 16'h00BB, 2'b01);
    push_b(16'h0100, 16'hAA00, 2'b10);
    push_b(16'h0103, 16'hBB00, 2'b10);
    send_byte(25'd0, 8'hAA, 1'b0);
    send_byte(25'd6, 8'hBB, 1'b0);
    finish_window(3);
    en_b = 1'b0;

    // Back-pressure with a source that honours ioctl_wait.
    mem_ack = 1'b0;
    ioctl_download = 1'b1;
    for (int k = 0; k < 6; k++) push_a(16'h0100 + 16'(k), {8'h41 + 8'(2*k), 8'h40 + 8'(2*k)}, 2'b11);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'h40 + 8'(i), 1'b1);
    cyc(1);
    check("wait_before", ioctl_wait, 1'b0);
    cyc(1);
    check("wait_after", ioctl_wait, 1'b1);
    fork
      begin
        for (int i = 4; i < 12; i++) send_byte(25'(i), 8'h40 + 8'(i), 1'b1);
      end
      begin
        cyc(30);
        check("wait_hold_ovf", overflow, 1'b0);
        check("wait_hold_req", mem_req, 1'b1);
        mem_ack = 1'b1;
      end
    join
    finish_window(4);
    check("wait_no_ovf", overflow, 1'b0);

    // Source ignoring wait overflows; then reset mid-window.
    mem_ack = 1'b0;
    ioctl_download = 1'b1;
    for (int k = 0; k < 4; k++) push_a(16'h0100 + 16'(k), {8'h51 + 8'(2*k), 8'h50 + 8'(2*k)}, 2'b11);
    for (int i = 0; i < 12; i++) send_byte(25'(i), 8'h50 + 8'(i), 1'b0);
    cyc(2);
    check("ovf_set", overflow, 1'b1);
    check("ovf_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    cyc(8);
    check("ovf_delivered", qa.size(), 0);
    check("ovf_sticky", overflow, 1'b1);
    send_byte(25'h40, 8'h99, 1'b0);
    reset = 1'b1;
    cyc(2);
    check_reset_outputs();
    reset = 1'b0;
    ioctl_download = 1'b0;
    cyc(5);
    check("rst_no_done", done_cnt, 4);
    check("rst_no_busy", busy, 1'b0);

    // Clean download after reset.
    ioctl_download = 1'b1;
    push_a(16'h0100, 16'h2211, 2'b11);
    push_a(16'h0101, 16'h4433, 2'b11);
    send_byte(25'd0, 8'h11, 1'b0);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b0);
    finish_window(5);

    // Non-matching index is ignored entirely.
    ioctl_index = 8'h01;
    busy_seen = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'h60 + 8'(i), 1'b0);
    ioctl_download = 1'b0;
    cyc(10);
    check("idx_busy_seen", busy_seen, 1'b0);
    check("idx_done", done_cnt, 5);
    check("idx_req", mem_req, 1'b0);
    ioctl_index = 8'h00;

    check("sb_a_empty", qa.size(), 0);
    check("sb_b_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
